// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for a 5-stage RV32I core.
// Captures the decoder's control bundle and operands for EX, detects load-use
// hazards (stalling PC and IF/ID for one bubble), kills the ID instruction on a
// taken branch, and keeps a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic [1:0]       id_alu_op,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [3:0]       id_funct,
  input  logic             ex_flush,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic [1:0]       ex_alu_op,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [3:0]       ex_funct,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RA_W-1:0]  REG_X0  = {RA_W{1'b0}};

  // Pipeline state
  logic             valid_r;
  logic             branch_r;
  logic             mem_read_r;
  logic             mem_to_reg_r;
  logic             mem_write_r;
  logic             alu_src_r;
  logic             reg_write_r;
  logic [1:0]       alu_op_r;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  rs1_data_r;
  logic [XLEN-1:0]  rs2_data_r;
  logic [XLEN-1:0]  imm_r;
  logic [RA_W-1:0]  rs1_r;
  logic [RA_W-1:0]  rs2_r;
  logic [RA_W-1:0]  rd_r;
  logic [3:0]       funct_r;
  logic [CNT_W-1:0] count_r;

  // Hazard / bubble decode
  logic uses_rs2_s;
  logic rd_match_s;
  logic hazard_s;
  logic bubble_s;
  logic count_inc_s;

  // Load-use detection against the instruction currently in EX; a flush masks it
  // because the dependent ID instruction is being discarded anyway.
  always_comb begin
    uses_rs2_s  = ~id_alu_src | id_mem_write;
    rd_match_s  = (rd_r == id_rs1) | (uses_rs2_s & (rd_r == id_rs2));
    hazard_s    = ~ex_flush & id_valid & valid_r & mem_read_r
                  & (rd_r != REG_X0) & rd_match_s;
    bubble_s    = ex_flush | hazard_s | ~id_valid;
    count_inc_s = (ex_flush | hazard_s) & id_valid;
  end

  assign pc_write_en    = ~hazard_s;
  assign if_id_write_en = ~hazard_s;

  // Data fields follow ID every cycle; only the control bundle is squashed by bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= {XLEN{1'b0}};
      rs1_data_r <= {XLEN{1'b0}};
      rs2_data_r <= {XLEN{1'b0}};
      imm_r      <= {XLEN{1'b0}};
      rs1_r      <= {RA_W{1'b0}};
      rs2_r      <= {RA_W{1'b0}};
      rd_r       <= {RA_W{1'b0}};
      funct_r    <= 4'b0000;
    end else begin
      pc_r       <= id_pc;
      rs1_data_r <= id_rs1_data;
      rs2_data_r <= id_rs2_data;
      imm_r      <= id_imm;
      rs1_r      <= id_rs1;
      rs2_r      <= id_rs2;
      rd_r       <= id_rd;
      funct_r    <= id_funct;
    end
  end

  // Control bundle and valid: zeroed on a bubble so EX performs no side effects.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r      <= 1'b0;
      branch_r     <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_to_reg_r <= 1'b0;
      mem_write_r  <= 1'b0;
      alu_src_r    <= 1'b0;
      reg_write_r  <= 1'b0;
      alu_op_r     <= 2'b00;
    end else if (bubble_s) begin
      valid_r      <= 1'b0;
      branch_r     <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_to_reg_r <= 1'b0;
      mem_write_r  <= 1'b0;
      alu_src_r    <= 1'b0;
      reg_write_r  <= 1'b0;
      alu_op_r     <= 2'b00;
    end else begin
      valid_r      <= 1'b1;
      branch_r     <= id_branch;
      mem_read_r   <= id_mem_read;
      mem_to_reg_r <= id_mem_to_reg;
      mem_write_r  <= id_mem_write;
      alu_src_r    <= id_alu_src;
      reg_write_r  <= id_reg_write;
      alu_op_r     <= id_alu_op;
    end
  end

  // Saturating count of bubbles that displaced a real instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_inc_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign ex_valid      = valid_r;
  assign ex_branch     = branch_r;
  assign ex_mem_read   = mem_read_r;
  assign ex_mem_to_reg = mem_to_reg_r;
  assign ex_mem_write  = mem_write_r;
  assign ex_alu_src    = alu_src_r;
  assign ex_reg_write  = reg_write_r;
  assign ex_alu_op     = alu_op_r;
  assign ex_pc         = pc_r;
  assign ex_rs1_data   = rs1_data_r;
  assign ex_rs2_data   = rs2_data_r;
  assign ex_imm        = imm_r;
  assign ex_rs1        = rs1_r;
  assign ex_rs2        = rs2_r;
  assign ex_rd         = rd_r;
  assign ex_funct      = funct_r;
  assign bubble_count  = count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed vector table, hand-written reset /
// saturation sequences, and randomized traffic against a behavioural model.
// A second instance with a 4-bit counter exercises saturation.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_branch, id_mem_read, id_mem_to_reg, id_mem_write;
  logic        id_alu_src, id_reg_write, ex_flush;
  logic [1:0]  id_alu_op;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;

  logic        ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;
  logic        ex_alu_src, ex_reg_write, pc_write_en, if_id_write_en;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic [15:0] bubble_count;

  logic        s_valid, s_branch, s_mem_read, s_mem_to_reg, s_mem_write;
  logic        s_alu_src, s_reg_write, s_pc_we, s_ifid_we;
  logic [1:0]  s_alu_op;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_funct;
  logic [3:0]  s_count;

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .bubble_count(bubble_count)
  );

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .ex_flush(ex_flush),
    .ex_valid(s_valid), .ex_branch(s_branch), .ex_mem_read(s_mem_read),
    .ex_mem_to_reg(s_mem_to_reg), .ex_mem_write(s_mem_write), .ex_alu_src(s_alu_src),
    .ex_reg_write(s_reg_write), .ex_alu_op(s_alu_op), .ex_pc(s_pc),
    .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct(s_funct),
    .pc_write_en(s_pc_we), .if_id_write_en(s_ifid_we), .bubble_count(s_count)
  );

  int errors = 0;
  int checks = 0;

  // Control byte layout: {branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}
  localparam logic [7:0] C_R  = 8'h11;  // R-type: RegWrite, ALUOp=10
  localparam logic [7:0] C_LW = 8'h63;  // load: MemRead, MemtoReg, ALUSrc, RegWrite
  localparam logic [7:0] C_SW = 8'h06;  // store: MemWrite, ALUSrc

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ex_ctrl();
    return {ex_branch, ex_mem_read, ex_mem_to_reg, ex_alu_op, ex_mem_write, ex_alu_src, ex_reg_write};
  endfunction

  task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] pc,
                       input logic fl);
    id_valid = v;
    {id_branch, id_mem_read, id_mem_to_reg, id_alu_op, id_mem_write, id_alu_src, id_reg_write} = c;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_pc = pc; ex_flush = fl;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_funct = 4'($urandom);
  endtask

  // Advance one edge and sample #1 after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  c;
    logic [4:0]  r1, r2, rd;
    logic [31:0] pc;
    logic        fl;
    logic        exp_en;
    logic        exp_valid;
    logic [7:0]  exp_ctrl;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vec[14];

  // Behavioural reference model state
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_funct;
  int          m_cnt, m_cnt_s;

  initial begin
    // In-order directed sequence, starting from reset state.
    vec[0]  = '{1'b1, C_R,  5'd3, 5'd4, 5'd5, 32'h100, 1'b0, 1'b1, 1'b1, C_R,  16'd0}; // plain R-type
    vec[1]  = '{1'b1, C_LW, 5'd1, 5'd0, 5'd5, 32'h104, 1'b0, 1'b1, 1'b1, C_LW, 16'd0}; // LW x5
    vec[2]  = '{1'b1, C_R,  5'd5, 5'd7, 5'd6, 32'h108, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1}; // ADD x6,x5,x7 stalls
    vec[3]  = '{1'b1, C_R,  5'd5, 5'd7, 5'd6, 32'h108, 1'b0, 1'b1, 1'b1, C_R,  16'd1}; // held ADD enters
    vec[4]  = '{1'b1, C_LW, 5'd2, 5'd0, 5'd8, 32'h10c, 1'b0, 1'b1, 1'b1, C_LW, 16'd1}; // LW x8
    vec[5]  = '{1'b1, C_SW, 5'd1, 5'd8, 5'd0, 32'h110, 1'b0, 1'b0, 1'b0, 8'h00, 16'd2}; // SW rs2=x8 stalls
    vec[6]  = '{1'b1, C_LW, 5'd2, 5'd0, 5'd8, 32'h114, 1'b0, 1'b1, 1'b1, C_LW, 16'd2}; // LW x8
    vec[7]  = '{1'b1, C_LW, 5'd9, 5'd8, 5'd10, 32'h118, 1'b0, 1'b1, 1'b1, C_LW, 16'd2}; // LW rs2 field=8, no stall
    vec[8]  = '{1'b1, C_LW, 5'd1, 5'd0, 5'd0, 32'h11c, 1'b0, 1'b1, 1'b1, C_LW, 16'd2}; // LW x0
    vec[9]  = '{1'b1, C_R,  5'd0, 5'd0, 5'd1, 32'h120, 1'b0, 1'b1, 1'b1, C_R,  16'd2}; // ADD x1,x0,x0 no stall
    vec[10] = '{1'b1, C_LW, 5'd1, 5'd0, 5'd5, 32'h124, 1'b0, 1'b1, 1'b1, C_LW, 16'd2}; // LW x5
    vec[11] = '{1'b1, C_R,  5'd5, 5'd5, 5'd6, 32'h128, 1'b1, 1'b1, 1'b0, 8'h00, 16'd3}; // flush beats hazard, +1
    vec[12] = '{1'b0, C_R,  5'd3, 5'd3, 5'd7, 32'h12c, 1'b0, 1'b1, 1'b0, 8'h00, 16'd3}; // idle not counted
    vec[13] = '{1'b0, C_R,  5'd3, 5'd3, 5'd7, 32'h130, 1'b1, 1'b1, 1'b0, 8'h00, 16'd3}; // idle flush not counted

    // Reset for two cycles with random inputs.
    drive(1'b1, 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom));
    rst = 1'b1;
    tick();
    drive(1'b1, 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b0);
    #1;
    check("reset_pc_write_en", 64'(pc_write_en), 64'd1);
    check("reset_if_id_write_en", 64'(if_id_write_en), 64'd1);
    tick();
    check("reset_valid_ctrl", {55'd0, ex_valid, ex_ctrl()}, 64'd0);
    check("reset_data", {ex_pc, ex_rs1_data | ex_rs2_data | ex_imm}, 64'd0);
    check("reset_idx", {45'd0, ex_rs1, ex_rs2, ex_rd, ex_funct}, 64'd0);
    check("reset_count", 64'(bubble_count), 64'd0);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      drive(vec[i].v, vec[i].c, vec[i].r1, vec[i].r2, vec[i].rd, vec[i].pc, vec[i].fl);
      #1;
      check($sformatf("vec%0d_pc_write_en", i), 64'(pc_write_en), 64'(vec[i].exp_en));
      check($sformatf("vec%0d_if_id_write_en", i), 64'(if_id_write_en), 64'(vec[i].exp_en));
      tick();
      check($sformatf("vec%0d_valid", i), 64'(ex_valid), 64'(vec[i].exp_valid));
      check($sformatf("vec%0d_ctrl", i), 64'(ex_ctrl()), 64'(vec[i].exp_ctrl));
      check($sformatf("vec%0d_rd", i), 64'(ex_rd), 64'(vec[i].rd));
      check($sformatf("vec%0d_pc", i), 64'(ex_pc), 64'(vec[i].pc));
      check($sformatf("vec%0d_count", i), 64'(bubble_count), 64'(vec[i].exp_cnt));
    end

    // Saturation: clean start, then 20 flushes with valid ID instructions.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, C_R, 5'd1, 5'd2, 5'd3, 32'h200, 1'b1);
      tick();
      check($sformatf("sat_small_%0d", k), 64'(s_count), 64'((k > 15) ? 15 : k));
    end
    check("sat_main_count", 64'(bubble_count), 64'd20);

    // Reset asserted while a load-use stall is being raised.
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5, 32'h300, 1'b0);
    tick();
    drive(1'b1, C_R, 5'd5, 5'd7, 5'd6, 32'h304, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_stall_en_from_state", 64'(pc_write_en), 64'd0);
    tick();
    check("rst_stall_valid_ctrl", {55'd0, ex_valid, ex_ctrl()}, 64'd0);
    check("rst_stall_data", {ex_pc, 27'd0, ex_rd}, 64'd0);
    check("rst_stall_counts", {bubble_count, 12'd0, s_count}, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_stall_en_after", 64'({pc_write_en, if_id_write_en}), 64'd3);

    // Randomized traffic against the reference model, from a clean reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_valid = 1'b0; m_ctrl = 8'h00; m_pc = 32'd0; m_rs1d = 32'd0; m_rs2d = 32'd0;
    m_imm = 32'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_funct = 4'd0;
    m_cnt = 0; m_cnt_s = 0;
    for (int n = 0; n < 400; n++) begin
      logic ld_ex, reads_rs2, stall, kill;
      drive(($urandom_range(0, 7) != 0), 8'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 31) == 0);
      // A real load in EX writing a non-zero register that ID reads must wait.
      ld_ex     = m_valid && m_ctrl[6] && (m_rd != 5'd0);
      reads_rs2 = !id_alu_src || id_mem_write;
      stall     = !ex_flush && id_valid && ld_ex &&
                  ((m_rd == id_rs1) || (reads_rs2 && (m_rd == id_rs2)));
      kill      = ex_flush || stall || !id_valid;
      #1;
      check($sformatf("rnd%0d_enables", n), 64'({pc_write_en, if_id_write_en}), stall ? 64'd0 : 64'd3);
      if (rst) begin
        m_valid = 1'b0; m_ctrl = 8'h00; m_pc = 32'd0; m_rs1d = 32'd0; m_rs2d = 32'd0;
        m_imm = 32'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_funct = 4'd0;
        m_cnt = 0; m_cnt_s = 0;
      end else begin
        m_valid = !kill;
        m_ctrl  = kill ? 8'h00 : {id_branch, id_mem_read, id_mem_to_reg, id_alu_op,
                                  id_mem_write, id_alu_src, id_reg_write};
        m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
        m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct = id_funct;
        if ((ex_flush || stall) && id_valid) begin
          m_cnt   = (m_cnt == 65535) ? 65535 : m_cnt + 1;
          m_cnt_s = (m_cnt_s == 15) ? 15 : m_cnt_s + 1;
        end
      end
      tick();
      check($sformatf("rnd%0d_valid_ctrl", n), {55'd0, ex_valid, ex_ctrl()}, {55'd0, m_valid, m_ctrl});
      check($sformatf("rnd%0d_pc_imm", n), {ex_pc, ex_imm}, {m_pc, m_imm});
      check($sformatf("rnd%0d_rdata", n), {ex_rs1_data, ex_rs2_data}, {m_rs1d, m_rs2d});
      check($sformatf("rnd%0d_idx", n), {45'd0, ex_rs1, ex_rs2, ex_rd, ex_funct},
            {45'd0, m_rs1, m_rs2, m_rd, m_funct});
      check($sformatf("rnd%0d_count", n), 64'(bubble_count), 64'(m_cnt));
      check($sformatf("rnd%0d_count_small", n), 64'(s_count), 64'(m_cnt_s));
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
